// File: rtl/dff_pkg.sv
// Shared constants and width helper for the dff_pipe register pipeline.
// No logic, no latency.
// No flow control.
package dff_pkg;

   localparam int DEF_WIDTH = 8;
   localparam int DEF_DEPTH = 3;

   // Number of bits needed to hold the values 0..n (same result as $clog2(n+1), minimum 1).
   function automatic int cnt_width(input int n);
      int w;
      w = 1;
      while ((1 << w) <= n) w = w + 1;
      return w;
   endfunction

endpackage

// File: rtl/dff_pipe_stage.sv
// One pipeline slot: a valid bit plus a data register.
// Captures the upstream word on the edge where adv is high; one cycle per stage.
// Holds both registers while adv is low; flush clears only the valid bit.
module dff_pipe_stage #(
   parameter int               WIDTH   = 8,
   parameter logic [WIDTH-1:0] RST_VAL = '0
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             adv,
   input  logic             up_valid,
   input  logic [WIDTH-1:0] up_data,
   output logic             v,
   output logic [WIDTH-1:0] d
);

   // Valid bit: cleared by flush, otherwise follows upstream whenever the slot advances.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v <= 1'b0;
      end else if (flush) begin
         v <= 1'b0;
      end else if (adv) begin
         v <= up_valid;
      end
   end

   // Data only moves when a real word arrives; bubbles leave the old value in place.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         d <= RST_VAL;
      end else if (!flush && adv && up_valid) begin
         d <= up_data;
      end
   end

endmodule

// File: rtl/dff_pipe.sv
// Flow-controlled register pipeline of DEPTH stages with bubble collapsing and flush.
// Latency DEPTH cycles unstalled (word accepted at edge N is on out_valid after edge N+DEPTH-1), 1 word/clk.
// Combinational ready chain: a stage advances if it is empty or everything downstream advances.
module dff_pipe
   import dff_pkg::*;
#(
   parameter int               WIDTH   = DEF_WIDTH,
   parameter int               DEPTH   = DEF_DEPTH,
   parameter logic [WIDTH-1:0] RST_VAL = '0
)(
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        flush,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic [WIDTH-1:0]            in_data,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [WIDTH-1:0]            out_data,
   output logic [cnt_width(DEPTH)-1:0] count
);

   localparam int CW = cnt_width(DEPTH);

   logic [DEPTH-1:0] v;
   logic [WIDTH-1:0] d    [DEPTH];
   logic [DEPTH-1:0] adv;
   logic [DEPTH-1:0] up_v;
   logic [WIDTH-1:0] up_d [DEPTH];
   logic             in_xfer;
   logic             out_xfer;

   // Ready chain, flattened: stage i advances unless it and every stage after it are full
   // while the sink stalls. Equivalent to adv[i] = !v[i] || adv[i+1], adv[DEPTH] = out_ready.
   always_comb begin
      logic all_full;
      adv      = '0;
      all_full = 1'b1;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         all_full = all_full & v[i];
         adv[i]   = out_ready | ~all_full;
      end
   end

   for (genvar g = 0; g < DEPTH; g++) begin : g_stage
      if (g == 0) begin : g_head
         assign up_v[g] = in_valid;
         assign up_d[g] = in_data;
      end else begin : g_body
         assign up_v[g] = v[g-1];
         assign up_d[g] = d[g-1];
      end

      dff_pipe_stage #(
         .WIDTH   (WIDTH),
         .RST_VAL (RST_VAL)
      ) u_stage (
         .clk      (clk),
         .rst      (rst),
         .flush    (flush),
         .adv      (adv[g]),
         .up_valid (up_v[g]),
         .up_data  (up_d[g]),
         .v        (v[g]),
         .d        (d[g])
      );
   end

   assign in_ready  = adv[0] && !flush;
   assign out_valid = v[DEPTH-1] && !flush;
   assign out_data  = d[DEPTH-1];
   assign in_xfer   = in_valid && in_ready;
   assign out_xfer  = out_valid && out_ready;

   // Occupancy tracks the valid bits: +1 per accepted word, -1 per delivered word, zero on flush.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (flush) begin
         count <= '0;
      end else if (in_xfer && !out_xfer) begin
         count <= count + CW'(1);
      end else if (!in_xfer && out_xfer) begin
         count <= count - CW'(1);
      end
   end

endmodule

// File: tb/tb_dff_pipe.sv
// Directed vector bench for dff_pipe (DEPTH=3, WIDTH=8) plus a random scoreboard run on DEPTH=1, WIDTH=1.
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
// Summary line reports comparisons made and comparisons failed.
module tb_dff_pipe;

   logic clk;
   logic rst;

   // DEPTH=3, WIDTH=8 instance
   logic       p_flush, p_iv, p_ir, p_ov, p_or;
   logic [7:0] p_id, p_od;
   logic [1:0] p_cnt;

   // DEPTH=1, WIDTH=1 instance
   logic       s_flush, s_iv, s_ir, s_ov, s_or;
   logic [0:0] s_id, s_od;
   logic [0:0] s_cnt;

   int checks   = 0;
   int failures = 0;

   dff_pipe #(.WIDTH(8), .DEPTH(3), .RST_VAL(8'h00)) dut3 (
      .clk       (clk),
      .rst       (rst),
      .flush     (p_flush),
      .in_valid  (p_iv),
      .in_ready  (p_ir),
      .in_data   (p_id),
      .out_valid (p_ov),
      .out_ready (p_or),
      .out_data  (p_od),
      .count     (p_cnt)
   );

   dff_pipe #(.WIDTH(1), .DEPTH(1), .RST_VAL(1'b0)) dut1 (
      .clk       (clk),
      .rst       (rst),
      .flush     (s_flush),
      .in_valid  (s_iv),
      .in_ready  (s_ir),
      .in_data   (s_id),
      .out_valid (s_ov),
      .out_ready (s_or),
      .out_data  (s_od),
      .count     (s_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       iv;
      logic [7:0] id;
      logic       ordy;
      logic       fl;
      logic       ir;
      logic       ov;
      logic [7:0] od;
      logic [1:0] cnt;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic add(input logic iv, input logic [7:0] id, input logic ordy, input logic fl,
                      input logic ir, input logic ov, input logic [7:0] od, input logic [1:0] cnt);
      vec_t r;
      r.iv = iv; r.id = id; r.ordy = ordy; r.fl = fl;
      r.ir = ir; r.ov = ov; r.od = od; r.cnt = cnt;
      vecs.push_back(r);
   endtask

   // Each row: drive inputs on the falling edge, check the cycle's outputs, let the rising edge act.
   task automatic run_vecs(input string tag);
      foreach (vecs[k]) begin
         @(negedge clk);
         p_iv    = vecs[k].iv;
         p_id    = vecs[k].id;
         p_or    = vecs[k].ordy;
         p_flush = vecs[k].fl;
         #1;
         check($sformatf("%s[%0d].in_ready", tag, k), 32'(p_ir), 32'(vecs[k].ir));
         check($sformatf("%s[%0d].out_valid", tag, k), 32'(p_ov), 32'(vecs[k].ov));
         check($sformatf("%s[%0d].count", tag, k), 32'(p_cnt), 32'(vecs[k].cnt));
         if (vecs[k].ov)
            check($sformatf("%s[%0d].out_data", tag, k), 32'(p_od), 32'(vecs[k].od));
      end
      vecs.delete();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [0:0] sb[$];
      logic [0:0] exp_d;
      int         mcnt;
      logic       pending;
      logic       exp_ir;
      logic       out_x;

      rst = 1'b0;
      p_flush = 1'b0; p_iv = 1'b0; p_id = 8'h00; p_or = 1'b0;
      s_flush = 1'b0; s_iv = 1'b0; s_id = 1'b0;  s_or = 1'b0;

      // Power-up reset
      #2 rst = 1'b1;
      #1;
      check("reset.out_valid", 32'(p_ov), 32'd0);
      check("reset.out_data", 32'(p_od), 32'h00);
      check("reset.count", 32'(p_cnt), 32'd0);
      check("reset.in_ready", 32'(p_ir), 32'd1);
      @(negedge clk);
      rst = 1'b0;

      // Test 1: fill with three words, then assert reset mid-stream
      add(1, 8'h55, 0, 0, 1, 0, 8'h00, 2'd0);
      add(1, 8'h66, 0, 0, 1, 0, 8'h00, 2'd1);
      add(1, 8'h77, 0, 0, 1, 0, 8'h00, 2'd2);
      run_vecs("fill_before_rst");
      @(negedge clk);
      p_iv = 1'b0;
      #1;
      check("pre_rst.count", 32'(p_cnt), 32'd3);
      check("pre_rst.out_data", 32'(p_od), 32'h55);
      check("pre_rst.in_ready", 32'(p_ir), 32'd0);
      rst = 1'b1;
      #1;
      check("mid_rst.out_valid", 32'(p_ov), 32'd0);
      check("mid_rst.out_data", 32'(p_od), 32'h00);
      check("mid_rst.count", 32'(p_cnt), 32'd0);
      @(negedge clk);
      rst = 1'b0;

      // Test 2: back-to-back stream 0x01..0x10 with out_ready held high, then drain
      for (int c = 0; c < 20; c++) begin
         add(c < 16, 8'(c + 1), 1, 0,
             1, (c >= 3) && (c <= 18), 8'(c - 2),
             (c < 3) ? 2'(c) : ((c <= 16) ? 2'd3 : 2'(19 - c)));
      end
      run_vecs("stream");

      // Test 3: fill, stall five cycles, release
      add(1, 8'hA1, 0, 0, 1, 0, 8'h00, 2'd0);
      add(1, 8'hA2, 0, 0, 1, 0, 8'h00, 2'd1);
      add(1, 8'hA3, 0, 0, 1, 0, 8'h00, 2'd2);
      for (int c = 0; c < 5; c++) add(0, 8'h00, 0, 0, 0, 1, 8'hA1, 2'd3);
      add(0, 8'h00, 1, 0, 1, 1, 8'hA1, 2'd3);
      add(0, 8'h00, 1, 0, 1, 1, 8'hA2, 2'd2);
      add(0, 8'h00, 1, 0, 1, 1, 8'hA3, 2'd1);
      add(0, 8'h00, 1, 0, 1, 0, 8'h00, 2'd0);
      run_vecs("backpressure");

      // Test 4: bubble collapse with out_ready low
      add(1, 8'h11, 0, 0, 1, 0, 8'h00, 2'd0);
      add(0, 8'h00, 0, 0, 1, 0, 8'h00, 2'd1);
      add(0, 8'h00, 0, 0, 1, 0, 8'h00, 2'd1);
      add(1, 8'h22, 0, 0, 1, 1, 8'h11, 2'd1);
      add(0, 8'h00, 0, 0, 1, 1, 8'h11, 2'd2);
      run_vecs("bubble_fill");
      @(negedge clk);
      #1;
      check("bubble.stage_valid", 32'(dut3.v), 32'b110);
      check("bubble.count", 32'(p_cnt), 32'd2);
      add(0, 8'h00, 0, 0, 1, 1, 8'h11, 2'd2);
      add(0, 8'h00, 1, 0, 1, 1, 8'h11, 2'd2);
      add(0, 8'h00, 1, 0, 1, 1, 8'h22, 2'd1);
      add(0, 8'h00, 1, 0, 1, 0, 8'h00, 2'd0);
      run_vecs("bubble_drain");

      // Test 5: flush while both handshakes would otherwise fire
      add(1, 8'h31, 0, 0, 1, 0, 8'h00, 2'd0);
      add(1, 8'h32, 0, 0, 1, 0, 8'h00, 2'd1);
      add(1, 8'h33, 0, 0, 1, 0, 8'h00, 2'd2);
      add(1, 8'h34, 1, 1, 0, 0, 8'h00, 2'd3);
      add(0, 8'h00, 1, 0, 1, 0, 8'h00, 2'd0);
      add(0, 8'h00, 1, 0, 1, 0, 8'h00, 2'd0);
      run_vecs("flush");
      @(negedge clk);
      #1;
      check("flush.data_kept", 32'(p_od), 32'h31);
      check("flush.stage_valid", 32'(dut3.v), 32'b000);
      add(1, 8'h35, 1, 0, 1, 0, 8'h00, 2'd0);
      add(0, 8'h00, 1, 0, 1, 0, 8'h00, 2'd1);
      add(0, 8'h00, 1, 0, 1, 0, 8'h00, 2'd1);
      add(0, 8'h00, 1, 0, 1, 1, 8'h35, 2'd1);
      add(0, 8'h00, 1, 0, 1, 0, 8'h00, 2'd0);
      run_vecs("after_flush");

      // Test 6: DEPTH=1 random valid/ready against a queue model
      mcnt    = 0;
      pending = 1'b0;
      for (int c = 0; c < 1000; c++) begin
         @(negedge clk);
         if (!pending) begin
            s_iv = 1'($urandom_range(0, 1));
            s_id = 1'($urandom_range(0, 1));
         end
         s_or = 1'($urandom_range(0, 1));
         #1;
         exp_ir = (mcnt == 0) || s_or;
         out_x  = (mcnt == 1) && s_or;
         check($sformatf("rand[%0d].in_ready", c), 32'(s_ir), 32'(exp_ir));
         check($sformatf("rand[%0d].out_valid", c), 32'(s_ov), 32'(mcnt == 1));
         check($sformatf("rand[%0d].count", c), 32'(s_cnt), 32'(mcnt));
         if (out_x) begin
            exp_d = sb.pop_front();
            check($sformatf("rand[%0d].out_data", c), 32'(s_od), 32'(exp_d));
            mcnt = mcnt - 1;
         end
         if (s_iv && exp_ir) begin
            sb.push_back(s_id);
            mcnt = mcnt + 1;
         end
         pending = s_iv && !exp_ir;
      end
      @(negedge clk);
      s_iv = 1'b0;
      s_or = 1'b1;
      #1;
      if (mcnt == 1) begin
         exp_d = sb.pop_front();
         check("rand_drain.out_data", 32'(s_od), 32'(exp_d));
         mcnt = 0;
      end
      @(negedge clk);
      #1;
      check("rand_drain.out_valid", 32'(s_ov), 32'd0);
      check("rand_drain.count", 32'(s_cnt), 32'd0);
      check("rand_drain.model_empty", 32'(sb.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
